// File: rtl/pixel_serializer.sv
// Pixel serializer: one-word prefetch register feeding a shift register that emits
// MSB-first 1/2/4/8-bit pixels. Optional pixel doubling when PIXEL_DOUBLE_EN is defined.
module pixel_serializer #(
    parameter int DW   = 16,
    parameter int PENW = 8
) (
    input  logic            dotclk_i,
    input  logic            reset_i,
    input  logic            enable_i,
    input  logic [1:0]      bpp_i,
    input  logic [DW-1:0]   dat_i,
    input  logic            valid_i,
    output logic            ready_o,
    output logic [PENW-1:0] pen_o,
    output logic            pen_valid_o,
    output logic            underflow_o
`ifdef PIXEL_DOUBLE_EN
    ,
    input  logic            double_i
`endif
);

    localparam int CW = $clog2(DW + 1);

    logic [DW-1:0]   hold_q, hold_d;
    logic            hold_full_q, hold_full_d;
    logic [1:0]      hold_bpp_q, hold_bpp_d;
    logic [DW-1:0]   sr_q, sr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [1:0]      sr_bpp_q, sr_bpp_d;
    logic [PENW-1:0] pen_q, pen_d;
    logic            pen_valid_q, pen_valid_d;
    logic            underflow_q, underflow_d;
    logic            phase_q, phase_d;
    logic            double_en;
    logic            repeat_pix;

`ifdef PIXEL_DOUBLE_EN
    assign double_en = double_i;
`else
    assign double_en = 1'b0;
`endif

    // phase_q=1 means the visible pixel still owes its second presentation.
    assign repeat_pix = double_en & phase_q;

    function automatic logic [PENW-1:0] top_pix(input logic [DW-1:0] w, input logic [1:0] bpp);
        logic [PENW-1:0] p;
        p = '0;
        case (bpp)
            2'd0:    p[0]   = w[DW-1];
            2'd1:    p[1:0] = w[DW-1 -: 2];
            2'd2:    p[3:0] = w[DW-1 -: 4];
            default: p[7:0] = w[DW-1 -: 8];
        endcase
        return p;
    endfunction

    function automatic logic [DW-1:0] shift_word(input logic [DW-1:0] w, input logic [1:0] bpp);
        logic [DW-1:0] s;
        case (bpp)
            2'd0:    s = {w[DW-2:0], 1'b0};
            2'd1:    s = {w[DW-3:0], 2'b0};
            2'd2:    s = {w[DW-5:0], 4'b0};
            default: s = {w[DW-9:0], 8'b0};
        endcase
        return s;
    endfunction

    assign ready_o     = ~hold_full_q;
    assign pen_o       = pen_q;
    assign pen_valid_o = pen_valid_q;
    assign underflow_o = underflow_q;

    always_comb begin
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        hold_bpp_d  = hold_bpp_q;
        sr_d        = sr_q;
        cnt_d       = cnt_q;
        sr_bpp_d    = sr_bpp_q;
        pen_d       = pen_q;
        pen_valid_d = 1'b0;
        underflow_d = 1'b0;
        phase_d     = phase_q;

        if (valid_i && ready_o) begin
            hold_d      = dat_i;
            hold_full_d = 1'b1;
            hold_bpp_d  = bpp_i;
        end

        if (enable_i) begin
            if (repeat_pix) begin
                pen_valid_d = 1'b1;
                phase_d     = 1'b0;
            end else if (cnt_q != '0) begin
                pen_d       = top_pix(sr_q, sr_bpp_q);
                sr_d        = shift_word(sr_q, sr_bpp_q);
                cnt_d       = cnt_q - 1'b1;
                pen_valid_d = 1'b1;
                phase_d     = 1'b1;
            end else if (hold_full_q) begin
                // Load and emit the first pixel in the same cycle so words stream gap-free.
                pen_d       = top_pix(hold_q, hold_bpp_q);
                sr_d        = shift_word(hold_q, hold_bpp_q);
                cnt_d       = CW'((DW >> hold_bpp_q) - 1);
                sr_bpp_d    = hold_bpp_q;
                hold_full_d = 1'b0;
                pen_valid_d = 1'b1;
                phase_d     = 1'b1;
            end else begin
                pen_d       = '0;
                underflow_d = 1'b1;
                phase_d     = 1'b0;
            end
        end
    end

    always_ff @(posedge dotclk_i) begin
        if (reset_i) begin
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            hold_bpp_q  <= 2'd0;
            sr_q        <= '0;
            cnt_q       <= '0;
            sr_bpp_q    <= 2'd0;
            pen_q       <= '0;
            pen_valid_q <= 1'b0;
            underflow_q <= 1'b0;
            phase_q     <= 1'b0;
        end else begin
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            hold_bpp_q  <= hold_bpp_d;
            sr_q        <= sr_d;
            cnt_q       <= cnt_d;
            sr_bpp_q    <= sr_bpp_d;
            pen_q       <= pen_d;
            pen_valid_q <= pen_valid_d;
            underflow_q <= underflow_d;
            phase_q     <= phase_d;
        end
    end

endmodule

// File: tb/tb_pixel_serializer.sv
// Directed bench for pixel_serializer (DW=16, PENW=8): a table of per-cycle vectors
// plus hand-written reset and pixel-doubling sequences.
module tb_pixel_serializer;

    typedef struct {
        logic        en;
        logic [1:0]  bpp;
        logic [15:0] dat;
        logic        valid;
        logic [7:0]  pen;
        logic        pv;
        logic        uf;
        logic        rdy;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [1:0]  bpp = 2'd0;
    logic [15:0] dat = '0;
    logic        valid = 1'b0;
    logic        rdy;
    logic [7:0]  pen;
    logic        pv;
    logic        uf;
    logic        dbl = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    vec_t vecs[$];

    pixel_serializer #(.DW(16), .PENW(8)) dut (
        .dotclk_i    (clk),
        .reset_i     (rst),
        .enable_i    (en),
        .bpp_i       (bpp),
        .dat_i       (dat),
        .valid_i     (valid),
        .ready_o     (rdy),
        .pen_o       (pen),
        .pen_valid_o (pv),
        .underflow_o (uf)
`ifdef PIXEL_DOUBLE_EN
        ,
        .double_i    (dbl)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic void add(input logic e, input logic [1:0] b, input logic [15:0] d,
                                input logic v, input logic [7:0] p, input logic epv,
                                input logic euf, input logic erdy);
        vec_t x;
        x.en = e; x.bpp = b; x.dat = d; x.valid = v;
        x.pen = p; x.pv = epv; x.uf = euf; x.rdy = erdy;
        vecs.push_back(x);
    endfunction

    initial begin
        logic [7:0] t1[16] = '{0,0,0,1, 0,0,1,0, 0,0,1,1, 0,1,0,0};
        logic [7:0] t4[8]  = '{2,1,0,1, 2,2,0,0};

        // Test 1: 1bpp word 1234
        add(0, 2'd0, 16'h1234, 1, 8'h00, 0, 0, 0);
        for (int i = 0; i < 16; i++) add(1, 2'd0, 16'h0, 0, t1[i], 1, 0, 1);
        add(0, 2'd0, 16'h0, 0, 8'h00, 0, 0, 1);
        // Test 2: 4bpp, 1234 then ABCD offered immediately
        add(0, 2'd2, 16'h1234, 1, 8'h00, 0, 0, 0);
        add(1, 2'd2, 16'hABCD, 1, 8'h01, 1, 0, 1);
        add(1, 2'd2, 16'hABCD, 1, 8'h02, 1, 0, 0);
        add(1, 2'd2, 16'h0,    0, 8'h03, 1, 0, 0);
        add(1, 2'd2, 16'h0,    0, 8'h04, 1, 0, 0);
        add(1, 2'd2, 16'h0,    0, 8'h0A, 1, 0, 1);
        add(1, 2'd2, 16'h0,    0, 8'h0B, 1, 0, 1);
        add(1, 2'd2, 16'h0,    0, 8'h0C, 1, 0, 1);
        add(1, 2'd2, 16'h0,    0, 8'h0D, 1, 0, 1);
        add(0, 2'd2, 16'h0,    0, 8'h0D, 0, 0, 1);
        // Test 3: 8bpp single word then underflow
        add(0, 2'd3, 16'h1234, 1, 8'h0D, 0, 0, 0);
        add(1, 2'd3, 16'h0, 0, 8'h12, 1, 0, 1);
        add(1, 2'd3, 16'h0, 0, 8'h34, 1, 0, 1);
        add(1, 2'd3, 16'h0, 0, 8'h00, 0, 1, 1);
        add(0, 2'd3, 16'h0, 0, 8'h00, 0, 0, 1);
        // Test 4: 2bpp word, bpp_i changed after accept
        add(0, 2'd1, 16'h91A0, 1, 8'h00, 0, 0, 0);
        for (int i = 0; i < 8; i++) add(1, 2'd3, 16'h0, 0, t4[i], 1, 0, 1);
        add(0, 2'd3, 16'h0, 0, 8'h00, 0, 0, 1);

        repeat (2) step();
        chk("reset_pv", {31'd0, pv}, 32'd0);
        chk("reset_pen", {24'd0, pen}, 32'd0);
        chk("reset_uf", {31'd0, uf}, 32'd0);
        rst = 1'b0;
        step();
        chk("post_reset_rdy", {31'd0, rdy}, 32'd1);
        chk("post_reset_pv", {31'd0, pv}, 32'd0);

        foreach (vecs[k]) begin
            en = vecs[k].en; bpp = vecs[k].bpp; dat = vecs[k].dat; valid = vecs[k].valid;
            step();
            $display("vec %0d: en=%0d bpp=%0d dat=%h -> pen=%h pv=%0d uf=%0d rdy=%0d",
                     k, vecs[k].en, vecs[k].bpp, vecs[k].dat, pen, pv, uf, rdy);
            chk($sformatf("vec%0d_pen", k), {24'd0, pen}, {24'd0, vecs[k].pen});
            chk($sformatf("vec%0d_pv", k), {31'd0, pv}, {31'd0, vecs[k].pv});
            chk($sformatf("vec%0d_uf", k), {31'd0, uf}, {31'd0, vecs[k].uf});
            chk($sformatf("vec%0d_rdy", k), {31'd0, rdy}, {31'd0, vecs[k].rdy});
        end

        // Test 5: reset in the middle of a word discards it
        en = 1'b0; bpp = 2'd0; dat = 16'hFFFF; valid = 1'b1;
        step();
        valid = 1'b0; en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            $display("t5 pixel %0d: pen=%h pv=%0d", i, pen, pv);
            chk($sformatf("t5_pen%0d", i), {24'd0, pen}, 32'd1);
        end
        en = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0;
        $display("t5 after reset: pen=%h pv=%0d rdy=%0d", pen, pv, rdy);
        chk("t5_rst_pv", {31'd0, pv}, 32'd0);
        chk("t5_rst_pen", {24'd0, pen}, 32'd0);
        chk("t5_rst_rdy", {31'd0, rdy}, 32'd1);
        en = 1'b1;
        step();
        $display("t5 enable after reset: pen=%h pv=%0d uf=%0d", pen, pv, uf);
        chk("t5_uf", {31'd0, uf}, 32'd1);
        chk("t5_uf_pv", {31'd0, pv}, 32'd0);
        en = 1'b0;
        step();
        chk("t5_uf_pulse_end", {31'd0, uf}, 32'd0);

`ifdef PIXEL_DOUBLE_EN
        // Test 6: pixel doubling at 8bpp
        begin
            logic [7:0] t6[4] = '{8'h12, 8'h12, 8'h34, 8'h34};
            rst = 1'b1; step(); rst = 1'b0;
            dbl = 1'b1; bpp = 2'd3; dat = 16'h1234; valid = 1'b1; en = 1'b0;
            step();
            valid = 1'b0; en = 1'b1;
            for (int i = 0; i < 4; i++) begin
                step();
                $display("t6 cycle %0d: pen=%h pv=%0d", i, pen, pv);
                chk($sformatf("t6_pen%0d", i), {24'd0, pen}, {24'd0, t6[i]});
                chk($sformatf("t6_pv%0d", i), {31'd0, pv}, 32'd1);
            end
            en = 1'b0; dbl = 1'b0;
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
